// File: rtl/loxodes_channel_serializer_if.sv
// Three-wire link to an external 74HC595-style shift register.
// The serializer drives it; the shift register model listens.
interface loxodes_channel_serializer_if;
  logic sr_data;
  logic sr_clk;
  logic sr_latch;

  modport master (
    output sr_data,
    output sr_clk,
    output sr_latch
  );

  modport slave (
    input sr_data,
    input sr_clk,
    input sr_latch
  );
endinterface

// File: rtl/loxodes_channel_serializer.sv
// Captures the channel word on change and shifts it MSB-first
// to an external 595, finishing each transfer with a latch pulse.
module loxodes_channel_serializer #(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [WIDTH-1:0]              channel,
  output logic                          busy,
  loxodes_channel_serializer_if.master  sr
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LATCH
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             pending_q, pending_d;
  logic [DW-1:0]    div_q, div_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic             data_q, data_d;
  logic             sclk_q, sclk_d;
  logic             latch_q, latch_d;
  logic             busy_q, busy_d;
  logic             div_done;

  assign div_done    = (div_q == DW'(CLK_DIV - 1));
  assign sr.sr_data  = data_q;
  assign sr.sr_clk   = sclk_q;
  assign sr.sr_latch = latch_q;
  assign busy        = busy_q;

  // Next state, datapath and the registered-output values.
  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    last_d    = last_q;
    pending_d = pending_q;
    div_d     = div_q;
    bit_d     = bit_q;
    unique case (state_q)
      IDLE: begin
        if (enable && (pending_q || channel != last_q)) begin
          shadow_d  = channel;
          bit_d     = BW'(WIDTH - 1);
          div_d     = '0;
          pending_d = 1'b0;
          state_d   = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (div_done) begin
          div_d   = '0;
          state_d = SHIFT_HI;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      SHIFT_HI: begin
        if (div_done) begin
          div_d = '0;
          if (bit_q == '0) begin
            state_d = LATCH;
          end else begin
            bit_d   = bit_q - 1'b1;
            state_d = SHIFT_LO;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      LATCH: begin
        if (div_done) begin
          div_d   = '0;
          last_d  = shadow_q;
          state_d = IDLE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    data_d  = 1'b0;
    if (state_d == SHIFT_LO || state_d == SHIFT_HI) begin
      data_d = shadow_d[bit_d];
    end
    sclk_d  = (state_d == SHIFT_HI);
    latch_d = (state_d == LATCH);
    busy_d  = (state_d != IDLE);
  end

  // State and output registers; reset abandons any transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shadow_q  <= '0;
      last_q    <= '0;
      pending_q <= 1'b1;
      div_q     <= '0;
      bit_q     <= '0;
      data_q    <= 1'b0;
      sclk_q    <= 1'b0;
      latch_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      last_q    <= last_d;
      pending_q <= pending_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      data_q    <= data_d;
      sclk_q    <= sclk_d;
      latch_q   <= latch_d;
      busy_q    <= busy_d;
    end
  end

endmodule

// File: doc/loxodes_channel_serializer.md
# loxodes_channel_serializer

Downstream output stage for the sequencer's 8-bit channel word. It captures the word whenever it changes and shifts it out MSB-first to an external 74HC595-style shift register over a three-wire interface: data, shift clock and latch. The external register's outputs then drive the physical channel loads. This frees board I/O and makes every update glitch-free, because the external outputs change only on the latch pulse.

## Interface
Parameters:
- `WIDTH`, default 8: channel word width; also the number of bits shifted per transfer.
- `CLK_DIV`, default 2: shift-clock half-period in `clk` cycles; legal values are 1 or greater.

Ports:
- `clk`, input, 1: sole clock; all logic is on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `enable`, input, 1: permits new transfers to start; it does not abort a transfer in flight.
- `channel`, input, `WIDTH`: channel word from the sequencer, sampled only in IDLE.
- `sr_data`, output, 1: serial data to the external register.
- `sr_clk`, output, 1: shift clock; the external register samples `sr_data` on its rising edge.
- `sr_latch`, output, 1: storage-register latch pulse, active-high.
- `busy`, output, 1: high while a transfer is in progress.

## Operation
- Internal state:
  - `shadow[WIDTH]`: word being shifted.
  - `last_sent[WIDTH]`: last word that was fully latched.
  - `pending`: set by reset, forces the first transfer.
  - `div_cnt`: 0 to `CLK_DIV`-1.
  - `bit_cnt`: 0 to `WIDTH`-1, width $clog2(WIDTH).
- FSM states are IDLE, SHIFT_LO, SHIFT_HI and LATCH.
- IDLE:
  - Start condition: `enable` high AND (`pending` OR `channel` != `last_sent`).
  - On start: `shadow` <= `channel`, `bit_cnt` <= `WIDTH`-1, `div_cnt` <= 0, state goes to SHIFT_LO, `pending` clears.
- SHIFT_LO:
  - `sr_clk` is 0 and `sr_data` = `shadow[bit_cnt]`.
  - After `CLK_DIV` cycles the state goes to SHIFT_HI.
- SHIFT_HI:
  - `sr_clk` is 1 and `sr_data` is held.
  - After `CLK_DIV` cycles: if `bit_cnt` = 0, go to LATCH; otherwise decrement `bit_cnt` and go to SHIFT_LO.
- LATCH:
  - `sr_latch` is 1, `sr_clk` is 0, `sr_data` is 0.
  - After `CLK_DIV` cycles: `last_sent` <= `shadow`, state goes to IDLE.
- `busy` is high in every state except IDLE.
- `channel` changes while busy are ignored. They are picked up on return to IDLE through the `last_sent` compare, so only the newest value is sent and intermediate values are dropped.
- `enable` low in IDLE holds the block in IDLE; `pending` and any mismatch are retained until `enable` returns high.
- Reset, including mid-transfer:
  - Next edge: IDLE, all outputs 0, `last_sent` = 0, `pending` = 1.
  - The transfer in flight is abandoned. No partial latch pulse is produced.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Timing
- Reset values: `sr_data` = 0, `sr_clk` = 0, `sr_latch` = 0, `busy` = 0.
- If the start condition is true at edge N:
  - At N+1: `busy` = 1 and `sr_data` = `channel[WIDTH-1]` as sampled at N.
  - First `sr_clk` rise: N+1+`CLK_DIV`.
  - Each bit lasts 2·`CLK_DIV` cycles. Bit k (MSB = 0) rises at N+1+(2k+1)·`CLK_DIV`.
  - `sr_latch` is high from N+1+2·`WIDTH`·`CLK_DIV` for `CLK_DIV` cycles.
  - `busy` falls at N+1+(2·`WIDTH`+1)·`CLK_DIV`. With the defaults this is N+35.
- `sr_data` is stable for `CLK_DIV` cycles before and `CLK_DIV` cycles after each `sr_clk` rise. It changes only on entry to SHIFT_LO.
- Back-to-back transfers: if the start condition holds on the cycle `busy` falls, the next transfer begins and `busy` rises again one cycle later. There is one IDLE cycle minimum between transfers.
- Latency from a `channel` change in IDLE to the latch rising edge is 1+2·`WIDTH`·`CLK_DIV` cycles.

## Test plan
- Reset release with `enable`=1 and `channel`=0x00: one forced transfer, 8 `sr_clk` rises all with `sr_data`=0, then one `sr_latch` pulse; `busy` is high for 34 cycles.
- `channel`=0xA5 with defaults: the `sr_data` values sampled at the 8 `sr_clk` rises are 1,0,1,0,0,1,0,1. The latch rises 33 cycles after the start edge. An external 595 model then reads 0xA5.
- Changes while busy: `channel` goes 0x01 → 0x02 → 0x03 during a 0x01 transfer. Required response: exactly one further transfer, carrying 0x03; 0x02 is never shifted.
- `enable`=0, then `channel`=0x7F, hold 50 cycles: `busy` stays 0 and there is no `sr_clk` activity. When `enable` goes to 1, a 0x7F transfer starts on the next edge.
- Assert `rst` during bit 3 of a transfer: the following cycle has all outputs 0, no latch pulse occurs, and after release a forced transfer of the current `channel` happens.
- `CLK_DIV`=1, `WIDTH`=8: `busy` is high for 17 cycles, `sr_clk` toggles every cycle, and back-to-back transfers are separated by exactly one IDLE cycle.
